// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and helpers for the data-memory arbiter
package dmem_arb_pkg;

    localparam logic [3:0] WE_RD = 4'b0000;
    localparam logic [3:0] WE_SB = 4'b0001;
    localparam logic [3:0] WE_SH = 4'b0011;
    localparam logic [3:0] WE_SW = 4'b1111;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic we_legal(input logic [3:0] we);
        case (we)
            WE_RD, WE_SB, WE_SH, WE_SW: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side port of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter with optional fixed m0 priority
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0 || ptr == M0) gnt0 = 1'b1;
            else                              gnt1 = 1'b1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // Pointer always moves to the master that lost (or did not ask) this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= M0;
        else if (gnt0) ptr <= M1;
        else if (gnt1) ptr <= M0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory between m0 and m1; DMEM_ARB_PERF_EN adds perf counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_we
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_conflict,
    output logic [15:0]       perf_gnt0,
    output logic [15:0]       perf_gnt1
`endif
);

    logic       req0, req1, gnt0, gnt1, granted;
    logic [3:0] sel_we;
    logic       rd_issue, bad_we;
    logic       rd_pend, rd_owner;

    // Requests are masked during reset so every output reads 0 while rst is high.
    assign req0 = m0.req & ~rst;
    assign req1 = m1.req & ~rst;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign m0.gnt  = gnt0;
    assign m1.gnt  = gnt1;
    assign granted = gnt0 | gnt1;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = WE_RD;
        mem_re    = 1'b0;
        sel_we    = WE_RD;
        if (gnt0) begin
            mem_addr  = m0.addr;
            mem_wdata = m0.wdata;
            sel_we    = m0.we;
        end else if (gnt1) begin
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
            sel_we    = m1.we;
        end
        if (granted) begin
            if (sel_we == WE_RD)     mem_re = 1'b1;
            else if (we_legal(sel_we)) mem_we = sel_we;
        end
    end

    assign rd_issue = granted && (sel_we == WE_RD);
    assign bad_we   = granted && !we_legal(sel_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= M0;
            err_we   <= 1'b0;
        end else begin
            rd_pend  <= rd_issue;
            rd_owner <= (rd_issue && gnt1) ? M1 : M0;
            err_we   <= err_we | bad_we;
        end
    end

    assign m0.rvalid = rd_pend && (rd_owner == M0);
    assign m1.rvalid = rd_pend && (rd_owner == M1);
    assign m0.rdata  = m0.rvalid ? mem_rdata : '0;
    assign m1.rdata  = m1.rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict <= '0;
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
        end else begin
            if (m0.req && m1.req && perf_conflict != 16'hFFFF) perf_conflict <= perf_conflict + 16'd1;
            if (gnt0 && perf_gnt0 != 16'hFFFF) perf_gnt0 <= perf_gnt0 + 16'd1;
            if (gnt1 && perf_gnt1 != 16'hFFFF) perf_gnt1 <= perf_gnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter, round-robin and fixed-priority builds
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) if_r0 ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) if_r1 ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) if_f0 ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) if_f1 ();

    logic [9:0]  r_addr, f_addr;
    logic [3:0]  r_we, f_we;
    logic        r_re, f_re;
    logic [31:0] r_wdata, f_wdata, r_rdata, f_rdata;
    logic        r_err, f_err;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] r_pc, r_pg0, r_pg1, f_pc, f_pg0, f_pg1;
`endif

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .m0(if_r0), .m1(if_r1),
        .mem_addr(r_addr), .mem_we(r_we), .mem_re(r_re), .mem_wdata(r_wdata),
        .mem_rdata(r_rdata), .err_we(r_err)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflict(r_pc), .perf_gnt0(r_pg0), .perf_gnt1(r_pg1)
`endif
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .m0(if_f0), .m1(if_f1),
        .mem_addr(f_addr), .mem_we(f_we), .mem_re(f_re), .mem_wdata(f_wdata),
        .mem_rdata(f_rdata), .err_we(f_err)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflict(f_pc), .perf_gnt0(f_pg0), .perf_gnt1(f_pg1)
`endif
    );

    logic [31:0] mem_r [0:1023];
    logic [31:0] mem_f [0:1023];

    always @(posedge clk) begin
        if (r_re) r_rdata <= mem_r[r_addr];
        if (f_re) f_rdata <= mem_f[f_addr];
        for (int b = 0; b < 4; b++) begin
            if (r_we[b]) mem_r[r_addr][8*b +: 8] <= r_wdata[8*b +: 8];
            if (f_we[b]) mem_f[f_addr][8*b +: 8] <= f_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                chk("rvalid0", if_r0.rvalid, e.owner == M0);
                chk("rvalid1", if_r1.rvalid, e.owner == M1);
                chk("rdata0", if_r0.rdata, (e.owner == M0) ? e.data : 32'h0);
                chk("rdata1", if_r1.rdata, (e.owner == M1) ? e.data : 32'h0);
            end else begin
                chk("idle_rvalid", {if_r0.rvalid, if_r1.rvalid}, 32'h0);
                chk("idle_rdata", if_r0.rdata | if_r1.rdata, 32'h0);
            end
        end
    end

    task automatic set_m(input int m, input logic req, input logic [9:0] addr,
                         input logic [3:0] we, input logic [31:0] wdata);
        if (m == 0) begin
            if_r0.req = req; if_r0.addr = addr; if_r0.we = we; if_r0.wdata = wdata;
            if_f0.req = req; if_f0.addr = addr; if_f0.we = we; if_f0.wdata = wdata;
        end else begin
            if_r1.req = req; if_r1.addr = addr; if_r1.we = we; if_r1.wdata = wdata;
            if_f1.req = req; if_f1.addr = addr; if_f1.we = we; if_f1.wdata = wdata;
        end
    endtask

    // Check one cycle's grant/issue at the negedge, queue any read return, then cross the edge.
    task automatic tick(input logic eg0, input logic eg1, input logic efg0, input logic efg1,
                        input logic ere, input logic [3:0] ewe, input logic [9:0] eaddr,
                        input logic [31:0] rdexp);
        exp_t e;
        @(negedge clk);
        chk("rr_gnt0", if_r0.gnt, eg0);
        chk("rr_gnt1", if_r1.gnt, eg1);
        chk("fp_gnt0", if_f0.gnt, efg0);
        chk("fp_gnt1", if_f1.gnt, efg1);
        chk("mem_re", r_re, ere);
        chk("mem_we", r_we, ewe);
        chk("mem_addr", r_addr, eaddr);
        if (ere) begin
            e.due = cyc + 1; e.owner = eg1 ? M1 : M0; e.data = rdexp;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_rdata = '0;
        f_rdata = '0;
        set_m(0, 1'b1, 10'd9, WE_RD, 32'h0);
        set_m(1, 1'b0, 10'd0, WE_RD, 32'h0);
        @(negedge clk);
        chk("rst_gnt", {if_r0.gnt, if_r1.gnt, if_f0.gnt, if_f1.gnt}, 32'h0);
        chk("rst_mem", {r_re, r_we, r_addr}, 32'h0);
        chk("rst_wdata", r_wdata, 32'h0);
        chk("rst_rvalid", {if_r0.rvalid, if_r1.rvalid, r_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        set_m(0, 1'b0, 10'd0, WE_RD, 32'h0);
        set_m(1, 1'b1, 10'd1, WE_SW, 32'h11111111);
        tick(0, 1, 0, 1, 0, WE_SW, 10'd1, 32'h0);
        set_m(1, 1'b1, 10'd2, WE_SW, 32'h22222222);
        tick(0, 1, 0, 1, 0, WE_SW, 10'd2, 32'h0);
        set_m(1, 1'b0, 10'd0, WE_RD, 32'h0);
        set_m(0, 1'b1, 10'd5, WE_SW, 32'hDEADBEEF);
        tick(1, 0, 1, 0, 0, WE_SW, 10'd5, 32'h0);
        set_m(0, 1'b1, 10'd5, WE_RD, 32'h0);
        tick(1, 0, 1, 0, 1, WE_RD, 10'd5, 32'hDEADBEEF);
        set_m(0, 1'b0, 10'd0, WE_RD, 32'h0);
        set_m(1, 1'b1, 10'd1, WE_RD, 32'h0);
        tick(0, 1, 0, 1, 1, WE_RD, 10'd1, 32'h11111111);

        set_m(0, 1'b1, 10'd1, WE_RD, 32'h0);
        set_m(1, 1'b1, 10'd2, WE_RD, 32'h0);
        tick(1, 0, 1, 0, 1, WE_RD, 10'd1, 32'h11111111);
        tick(0, 1, 1, 0, 1, WE_RD, 10'd2, 32'h22222222);
        tick(1, 0, 1, 0, 1, WE_RD, 10'd1, 32'h11111111);
        tick(0, 1, 1, 0, 1, WE_RD, 10'd2, 32'h22222222);

        set_m(0, 1'b0, 10'd0, WE_RD, 32'h0);
        set_m(1, 1'b1, 10'd7, 4'b0101, 32'hCAFEF00D);
        chk("err_before", r_err, 1'b0);
        tick(0, 1, 0, 1, 0, WE_RD, 10'd7, 32'h0);
        set_m(1, 1'b0, 10'd0, WE_RD, 32'h0);
        chk("err_set", r_err, 1'b1);
        tick(0, 0, 0, 0, 0, WE_RD, 10'd0, 32'h0);
        chk("err_sticky", r_err, 1'b1);
        chk("mem_wdata_idle", r_wdata, 32'h0);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_conflict", r_pc, 16'd4);
        chk("perf_gnt0", r_pg0, 16'd4);
        chk("perf_gnt1", r_pg1, 16'd6);
        chk("fp_perf_gnt0", f_pg0, 16'd6);
`endif

        set_m(0, 1'b1, 10'd5, WE_RD, 32'h0);
        @(negedge clk);
        chk("pre_rst_gnt0", if_r0.gnt, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {if_r0.gnt, if_r1.gnt, r_re, r_we, r_err}, 32'h0);
        chk("mid_rst_addr", r_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_edge_rvalid", {if_r0.rvalid, if_r1.rvalid}, 32'h0);
        chk("post_edge_rdata", if_r0.rdata, 32'h0);
        rst = 1'b0;
        tick(1, 0, 1, 0, 1, WE_RD, 10'd5, 32'hDEADBEEF);
        set_m(0, 1'b0, 10'd0, WE_RD, 32'h0);
        tick(0, 0, 0, 0, 0, WE_RD, 10'd0, 32'h0);
        tick(0, 0, 0, 0, 0, WE_RD, 10'd0, 32'h0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (10-bit word address, 4-bit byte-write enable, registered 1-cycle read) between two requesters: m0 = core load/store unit, m1 = debug/DMA port.
- Arbitrates per cycle and drives the memory port.
- Tracks which requester owns each in-flight read, then steers the returned word back to that requester.
- Sits between the pipeline MEM stage / debug bridge and the data memory.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  m0 access request, held until granted
- m0_addr  in  ADDR_W  m0 word address
- m0_we  in  4  0000 = read, 0001 = SB, 0011 = SH, 1111 = SW
- m0_wdata  in  DATA_W  m0 write data
- m0_gnt  out  1  m0 access issued this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  DATA_W  m0 read data
- m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1
- mem_addr  out  ADDR_W  to memory address
- mem_we  out  4  to memory byte-write enable
- mem_re  out  1  to memory read enable
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory registered read output
- err_we  out  1  sticky flag: illegal we code granted

Behaviour:
- **Reset:**
  - Reset is asynchronous and active-high. Clock is clk, reset is rst.
  - Reset clears all state: rd_pend = 0, rd_owner = 0, rr_ptr = m0, err_we = 0.
  - During and after reset, all outputs are 0.
- **Grant (combinational, one access per cycle):**
  - Only one requesting: that requester wins.
  - Both requesting, FIXED_PRIO = 1: m0 wins.
  - Both requesting, FIXED_PRIO = 0: the master selected by rr_ptr wins. After any grant, rr_ptr points to the non-winner.
  - The winner's gnt = 1, loser's gnt = 0. A requester must hold req, addr, we and wdata stable until it sees gnt.
  - No request: gnt = 0, mem_re = 0, mem_we = 0000, mem_addr and mem_wdata = 0.
- **Issue:**
  - mem_addr and mem_wdata come from the winner.
  - Winner we = 0000 (read): mem_re = 1, mem_we = 0000.
  - Winner we legal and non-zero (write): mem_we = we, mem_re = 0. Writes complete in the grant cycle; no rvalid.
  - Illegal we (any code other than 0000/0001/0011/1111): gnt still asserted, mem_we forced to 0000, mem_re = 0, err_we set sticky until rst.
- **Read return:**
  - A granted read sets rd_pend = 1 and rd_owner = winner on the next edge.
  - In the cycle after grant, rX_rvalid = 1 for the owner only, and rX_rdata = mem_rdata.
  - Non-owner rdata is 0. Both rdata are 0 when rvalid = 0.
  - Latency is exactly 1 cycle after gnt.
- **Back-to-back:**
  - A new grant is allowed in the same cycle that a previous read returns, giving throughput of 1 access per cycle.
  - rd_pend/rd_owner reload every cycle and clear when no read is granted.
- **Read after write, same address, consecutive cycles:** the read returns the new data, because memory writes on edge N and the read samples on edge N+1.
- **rst asserted mid-read:** the pending read is discarded and no rvalid is produced after reset.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- **Defined:**
  - Adds 16-bit saturating counters: perf_conflict (cycles with both req = 1), perf_gnt0 and perf_gnt1 (grants per master).
  - These appear as outputs of width 16 and reset to 0. Counters hold at 16'hFFFF.
- **Undefined:** the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - localparams WE_RD = 4'b0000, WE_SB = 4'b0001, WE_SH = 4'b0011, WE_SW = 4'b1111.
  - master id constants M0 = 1'b0, M1 = 1'b1.
  - function we_legal().
- Sub-module rr_arb2 (2-way round-robin with FIXED_PRIO override and pointer register): instantiated once. The rest is the issue mux, read-tracking registers and error flag.

Test Plan:
- m0 SW addr 5 data 32'hDEADBEEF, then m0 read addr 5 -> gnt each cycle; m0_rvalid 1 cycle after read gnt with rdata 32'hDEADBEEF; m1_rvalid stays 0.
- m0 and m1 both read (addr 1, addr 2) for 4 cycles, FIXED_PRIO = 0 -> grants alternate m0, m1, m0, m1; each rvalid goes to the correct owner with the matching word.
- Same contention with FIXED_PRIO = 1 -> m0 granted every cycle, m1_gnt = 0 throughout.
- m1 we = 4'b0101 -> m1_gnt = 1, mem_we = 0000, err_we = 1 and stays 1 until rst.
- m0 read granted, rst pulsed before the next edge -> no m0_rvalid, all outputs 0, then normal grant after rst deasserts.
- With DMEM_ARB_PERF_EN: 3 contention cycles -> perf_conflict = 3; perf_gnt0 + perf_gnt1 equals the total number of grants.
